// File: rtl/csoc_byte_port.sv
// rtl/csoc_byte_port.sv - tester byte-link responder: show-ahead rx FIFO and gapped tx strobes
module csoc_byte_port #(
  parameter int DEPTH   = 4,
  parameter int MIN_GAP = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_read_i,
  input  logic [7:0] data_i,
  output logic       uart_write_o,
  output logic [7:0] data_o,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_pop,
  output logic       rx_overflow,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL     = (AW+1)'(DEPTH);
  localparam logic [3:0]  GAP_LOAD = 4'(MIN_GAP);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0]   count_q;
  logic          overflow_q;
  logic          pop_ok, push_ok;

  // A pop on an empty FIFO is ignored; a full FIFO still takes a byte if the head leaves this cycle.
  assign pop_ok  = rx_pop && (count_q != '0);
  assign push_ok = uart_read_i && ((count_q != FULL) || pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (uart_read_i && !push_ok) overflow_q <= 1'b1;
    end
  end

  assign rx_valid    = (count_q != '0);
  assign rx_data     = mem_q[rd_ptr_q];
  assign rx_overflow = overflow_q;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STROBE,
    S_GAP
  } tx_state_e;

  tx_state_e  state_q, state_d;
  logic [3:0] gap_q, gap_d;
  logic [7:0] data_q, data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
    end
  end

  // data_q doubles as the holding register, so data_o moves only on entry to STROBE.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          data_d  = tx_data;
          state_d = S_STROBE;
        end
      end
      S_STROBE: begin
        if (GAP_LOAD == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_GAP;
          gap_d   = GAP_LOAD;
        end
      end
      S_GAP: begin
        gap_d = gap_q - 1'b1;
        if (gap_q <= 4'd1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx_ready     = (state_q == S_IDLE);
  assign uart_write_o = (state_q == S_STROBE);
  assign data_o       = data_q;

endmodule

// File: tb/tb_csoc_byte_port.sv
// tb/tb_csoc_byte_port.sv - randomized and directed checks of csoc_byte_port against a queue/timestamp model
module tb_csoc_byte_port;

  localparam int DEPTH   = 4;
  localparam int MIN_GAP = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_read_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       rx_pop = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       uart_write_o;
  logic [7:0] data_o;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_overflow;
  logic       tx_ready;

  csoc_byte_port #(.DEPTH(DEPTH), .MIN_GAP(MIN_GAP)) dut (
    .clk          (clk),
    .rst          (rst),
    .uart_read_i  (uart_read_i),
    .data_i       (data_i),
    .uart_write_o (uart_write_o),
    .data_o       (data_o),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_pop       (rx_pop),
    .rx_overflow  (rx_overflow),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Inputs as seen by the DUT at each rising edge.
  logic       s_rst, s_rd, s_pop, s_txv;
  logic [7:0] s_di, s_txd;
  bit         s_seen = 1'b0;
  always @(posedge clk) begin
    s_rst  <= rst;
    s_rd   <= uart_read_i;
    s_di   <= data_i;
    s_pop  <= rx_pop;
    s_txv  <= tx_valid;
    s_txd  <= tx_data;
    s_seen <= 1'b1;
  end

  // Model: FIFO is a queue; transmitter is the cycle of its last strobe and the first cycle it is ready again.
  logic [7:0] mq[$];
  bit         m_ovf, m_pop, m_push, started;
  logic [7:0] m_data;
  int         strobe_at, ready_from;

  always @(negedge clk) begin
    if (s_seen) begin
      cyc++;
      if (s_rst) begin
        started    = 1'b1;
        mq.delete();
        m_ovf      = 1'b0;
        m_data     = 8'h00;
        strobe_at  = -1;
        ready_from = cyc;
      end else if (started) begin
        m_pop  = s_pop && (mq.size() > 0);
        m_push = s_rd && ((mq.size() < DEPTH) || m_pop);
        if (m_pop) void'(mq.pop_front());
        if (m_push) mq.push_back(s_di);
        else if (s_rd) m_ovf = 1'b1;
        if (s_txv && (cyc - 1 >= ready_from)) begin
          m_data     = s_txd;
          strobe_at  = cyc;
          ready_from = cyc + MIN_GAP + 1;
        end
      end
      if (started) begin
        chk("rx_valid", rx_valid, mq.size() != 0);
        if (mq.size() != 0) chk("rx_data", rx_data, mq[0]);
        chk("rx_overflow", rx_overflow, m_ovf);
        chk("uart_write_o", uart_write_o, cyc == strobe_at);
        chk("data_o", data_o, m_data);
        chk("tx_ready", tx_ready, cyc >= ready_from);
      end
    end
  end

  logic [7:0] exp_wrap [4] = '{8'hA2, 8'hA3, 8'hA4, 8'hA5};
  logic [7:0] exp_ovf  [4] = '{8'h11, 8'h12, 8'h13, 8'hFF};
  logic [7:0] tx_bytes [3] = '{8'h31, 8'h32, 8'h33};
  int         scyc [3];
  logic [7:0] sdat [3];
  int         idx, nstr, tacc;

  initial begin
    rst = 1'b1; uart_read_i = 1'b1; data_i = 8'h42; tx_valid = 1'b1; tx_data = 8'hEE;
    repeat (2) @(negedge clk);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_uart_write", uart_write_o, 0);
    chk("reset_data_o", data_o, 8'h00);
    chk("reset_overflow", rx_overflow, 0);
    rst = 1'b0; uart_read_i = 1'b0; tx_valid = 1'b0;
    @(negedge clk);
    chk("reset_tx_ready", tx_ready, 1);

    for (int i = 0; i < 3; i++) begin
      uart_read_i = 1'b1; data_i = 8'(8'hA1 + i);
      @(negedge clk);
    end
    uart_read_i = 1'b0; rx_pop = 1'b1;
    @(negedge clk);
    rx_pop = 1'b0; uart_read_i = 1'b1; data_i = 8'hA4;
    @(negedge clk);
    data_i = 8'hA5;
    @(negedge clk);
    uart_read_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("wrap_valid", rx_valid, 1);
      chk("wrap_data", rx_data, exp_wrap[i]);
      rx_pop = 1'b1;
      @(negedge clk);
    end
    rx_pop = 1'b0;
    chk("wrap_empty", rx_valid, 0);

    for (int i = 0; i < 4; i++) begin
      uart_read_i = 1'b1; data_i = 8'(8'h10 + i);
      @(negedge clk);
    end
    data_i = 8'hFF;
    @(negedge clk);
    uart_read_i = 1'b0;
    chk("ovf_set", rx_overflow, 1);
    chk("ovf_head", rx_data, 8'h10);
    uart_read_i = 1'b1; data_i = 8'hFF; rx_pop = 1'b1;
    @(negedge clk);
    uart_read_i = 1'b0; rx_pop = 1'b0;
    chk("ovf_sticky", rx_overflow, 1);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_drain", rx_data, exp_ovf[i]);
      rx_pop = 1'b1;
      @(negedge clk);
    end
    rx_pop = 1'b0;
    chk("ovf_drained", rx_valid, 0);

    uart_read_i = 1'b1; data_i = 8'h5A; rx_pop = 1'b1;
    @(negedge clk);
    uart_read_i = 1'b0; rx_pop = 1'b0;
    chk("empty_pushpop_valid", rx_valid, 1);
    chk("empty_pushpop_data", rx_data, 8'h5A);
    rx_pop = 1'b1;
    @(negedge clk);
    rx_pop = 1'b0;

    idx = 0; nstr = 0; tacc = -100;
    for (int c = 0; c < 20; c++) begin
      if (idx < 3) begin
        tx_valid = 1'b1; tx_data = tx_bytes[idx];
        if (tx_ready) begin
          if (idx == 0) tacc = c;
          idx++;
        end
      end else begin
        tx_valid = 1'b0;
      end
      @(negedge clk);
      if (uart_write_o) begin
        if (nstr < 3) begin
          scyc[nstr] = c + 1;
          sdat[nstr] = data_o;
        end
        nstr++;
      end
    end
    tx_valid = 1'b0;
    chk("tx_strobe_count", nstr, 3);
    if (nstr >= 3) begin
      chk("tx_first_latency", scyc[0] - tacc, 1);
      chk("tx_spacing_1", scyc[1] - scyc[0], MIN_GAP + 2);
      chk("tx_spacing_2", scyc[2] - scyc[1], MIN_GAP + 2);
      for (int i = 0; i < 3; i++) chk("tx_strobe_data", sdat[i], tx_bytes[i]);
    end
    chk("tx_data_hold", data_o, 8'h33);

    tx_valid = 1'b1; tx_data = 8'h77; uart_read_i = 1'b1; data_i = 8'h99;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("abort_strobe", uart_write_o, 1);
    chk("abort_strobe_data", data_o, 8'h77);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; uart_read_i = 1'b0;
    chk("abort_no_write", uart_write_o, 0);
    chk("abort_data_o", data_o, 8'h00);
    chk("abort_rx_flushed", rx_valid, 0);
    chk("abort_tx_ready", tx_ready, 1);
    nstr = 0;
    repeat (8) begin
      @(negedge clk);
      if (uart_write_o) nstr++;
    end
    chk("abort_no_strobe", nstr, 0);

    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 299) == 0);
      uart_read_i = ($urandom_range(0, 3) != 0);
      data_i      = 8'($urandom);
      rx_pop      = ((c / 500) % 3 == 0) ? ($urandom_range(0, 3) == 0) :
                    ((c / 500) % 3 == 1) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 3) != 0);
      tx_valid    = ($urandom_range(0, 2) != 0);
      tx_data     = 8'($urandom);
      @(negedge clk);
    end
    rst = 1'b0; uart_read_i = 1'b0; rx_pop = 1'b0; tx_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/csoc_byte_port.md
# csoc_byte_port

CSoC-side responder for the 8-bit parallel byte link that the FPGA test controller drives (strobe pair plus one data bus per direction). It captures tester-written bytes into a small show-ahead FIFO for the CSoC core and serialises core-produced bytes back to the tester as single-cycle write strobes with a guaranteed inter-byte gap. The block runs entirely on the CSoC clock that the tester supplies, and sits between the CSoC pads and the on-chip UART/console logic.

## Interface
- DEPTH, 4: receive FIFO depth in bytes; power of two, 2..16.
- MIN_GAP, 2: idle cycles forced after each transmit strobe; 0..15.

- clk  in  1  CSoC clock (driven by tester); all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- uart_read_i  in  1  tester strobe: data_i holds a valid byte this cycle.
- data_i  in  8  byte from tester, sampled only when uart_read_i=1.
- uart_write_o  out  1  one-cycle strobe: data_o valid for the tester.
- data_o  out  8  byte to tester; holds last transmitted value.
- rx_valid  out  1  FIFO non-empty; rx_data valid.
- rx_data  out  8  head of receive FIFO (show-ahead).
- rx_pop  in  1  core consumes head; ignored when rx_valid=0.
- rx_overflow  out  1  sticky: a byte was dropped because FIFO was full.
- tx_valid  in  1  core offers tx_data.
- tx_data  in  8  byte to send.
- tx_ready  out  1  transmitter accepts a byte this cycle.

## Operation
- Receive FIFO: circular buffer, DEPTH entries, read/write pointers of clog2(DEPTH) bits wrapping modulo DEPTH, occupancy counter clog2(DEPTH)+1 bits.
- Push when uart_read_i=1 and (count<DEPTH or rx_pop accepted same cycle).
- Full and uart_read_i=1 with no pop: byte dropped, FIFO unchanged, rx_overflow set; cleared only by rst.
- Full with simultaneous push and pop: both happen, count stays DEPTH, no overflow.
- Empty with simultaneous push and pop: pop ignored, push happens, count becomes 1.
- rx_data = mem[rd_ptr]; undefined content when rx_valid=0 (bench must not check it).
- Transmit FSM, three states:
  - IDLE: tx_ready=1. tx_valid=1 latches tx_data into holding register, go STROBE.
  - STROBE: uart_write_o=1, data_o=holding register; tx_ready=0. Next: GAP with counter loaded MIN_GAP, or IDLE if MIN_GAP=0.
  - GAP: tx_ready=0, uart_write_o=0; counter decrements each cycle; leaves to IDLE on the cycle counter reaches 0 (MIN_GAP cycles spent in GAP).
- tx_ready is combinational from state (state==IDLE); tx_data is never sampled outside IDLE.
- data_o is registered and changes only on entry to STROBE; it holds its value afterwards.
- Receive and transmit paths are fully independent; simultaneous uart_read_i and an active transmit have no interaction.

## Timing
- Reset (rst=1 at a rising edge): FIFO emptied, pointers/count 0, rx_valid=0, rx_overflow=0, state IDLE, uart_write_o=0, data_o=8'h00, tx_ready=1 from the following cycle. rst mid-transfer aborts: a latched but unsent byte is discarded; FIFO contents are lost.
- Receive latency: uart_read_i at edge N -> rx_valid=1 and rx_data valid after edge N (visible cycle N+1).
- Pop: rx_pop at edge N -> next entry (or rx_valid=0) visible cycle N+1.
- Transmit latency: tx_valid&tx_ready at edge N -> uart_write_o=1 during cycle N+1, exactly one cycle.
- Strobe spacing: consecutive uart_write_o pulses are MIN_GAP+2 cycles apart at back-to-back tx_valid (MIN_GAP=2 -> every 4 cycles; MIN_GAP=0 -> every 2 cycles).
- Sustained receive: one byte per cycle accepted while not full.

## Test plan
- Reset: hold rst 2 cycles with uart_read_i=1, tx_valid=1 -> rx_valid=0, uart_write_o=0, data_o=8'h00, rx_overflow=0; tx_ready=1 first cycle after rst drops.
- FIFO order/wrap: DEPTH=4, write 8'hA1..8'hA3, pop one, write 8'hA4, 8'hA5 -> rx_data sequence A2,A3,A4,A5 across pointer wrap, rx_valid falls after 4th pop.
- Overflow: fill 4 bytes 8'h10..8'h13, strobe 8'hFF with no pop -> FIFO still 10..13, rx_overflow=1 until rst; repeat at full with same-cycle rx_pop -> 8'hFF accepted, no new drop.
- Empty push+pop: empty FIFO, uart_read_i=1 data 8'h5A with rx_pop=1 -> rx_valid=1, rx_data=8'h5A next cycle.
- Transmit spacing: MIN_GAP=2, tx_valid held with 8'h31,8'h32,8'h33 -> three single-cycle strobes 4 cycles apart, data_o 31,32,33, first strobe 1 cycle after acceptance; data_o stays 8'h33 afterwards.
- Reset mid-transmit: accept 8'h77, assert rst in STROBE/GAP -> no further strobe, data_o=8'h00, tx_ready=1 after release; concurrently running rx traffic is flushed.
